// File: rtl/req_tag_alloc_if.sv
// Tag allocator bus: offer/accept handshake, completion beats and status.
`default_nettype none
`timescale 1ns/1ps
interface req_tag_alloc_if #(
  parameter int TAG_WIDTH = 3
);
  logic                 alloc_vld;
  logic [TAG_WIDTH-1:0] alloc_tag;
  logic                 alloc_rdy;
  logic                 cpl_vld;
  logic                 cpl_done;
  logic [TAG_WIDTH-1:0] cpl_tag;
  logic [TAG_WIDTH:0]   outstanding;
  logic                 all_idle;
  logic                 rel_err;

  modport master (
    output alloc_vld, alloc_tag, outstanding, all_idle, rel_err,
    input  alloc_rdy, cpl_vld, cpl_done, cpl_tag
  );

  modport slave (
    input  alloc_vld, alloc_tag, outstanding, all_idle, rel_err,
    output alloc_rdy, cpl_vld, cpl_done, cpl_tag
  );
endinterface
`default_nettype wire

// File: rtl/req_tag_alloc.sv
// req_tag_alloc: round-robin tag allocator with registered offer and
// release-on-final-completion, outstanding count and illegal-release flag.
`default_nettype none
`timescale 1ns/1ps
module req_tag_alloc #(
  parameter int TAG_COUNT = 8,
  parameter int TAG_WIDTH = $clog2(TAG_COUNT)
) (
  input  logic           clk,
  input  logic           rst_n,
  req_tag_alloc_if.master bus
);

  logic [TAG_COUNT-1:0] free_q, free_d;
  logic                 offer_vld_q, offer_vld_d;
  logic [TAG_WIDTH-1:0] offer_tag_q, offer_tag_d;
  logic [TAG_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [TAG_WIDTH:0]   outstanding_q, outstanding_d;
  logic                 rel_err_q, rel_err_d;

  logic                 fire;
  logic                 cpl_last;
  logic                 tag_in_range;
  logic                 tag_is_free;
  logic                 rel_legal;
  logic                 any_free;
  logic                 load;
  logic [TAG_WIDTH-1:0] pick;

  assign fire     = offer_vld_q && bus.alloc_rdy;
  assign cpl_last = bus.cpl_vld && bus.cpl_done;

  always_comb begin
    tag_in_range = 1'b0;
    tag_is_free  = 1'b0;
    for (int j = 0; j < TAG_COUNT; j++) begin
      if (bus.cpl_tag == TAG_WIDTH'(j)) begin
        tag_in_range = 1'b1;
        tag_is_free  = free_q[j];
      end
    end
  end

  // The offered tag is already cleared in the free map, so it must be
  // excluded explicitly or a release could reclaim it before acceptance.
  assign rel_legal = cpl_last && tag_in_range && !tag_is_free &&
                     !(offer_vld_q && (offer_tag_q == bus.cpl_tag));

  // Rotating priority: first pass from rr_ptr to the top, then wrap to 0.
  always_comb begin
    any_free = 1'b0;
    pick     = '0;
    for (int j = 0; j < TAG_COUNT; j++) begin
      if (!any_free && free_q[j] && (j >= int'(rr_ptr_q))) begin
        any_free = 1'b1;
        pick     = TAG_WIDTH'(j);
      end
    end
    for (int j = 0; j < TAG_COUNT; j++) begin
      if (!any_free && free_q[j] && (j < int'(rr_ptr_q))) begin
        any_free = 1'b1;
        pick     = TAG_WIDTH'(j);
      end
    end
  end

  assign load = (!offer_vld_q || fire) && any_free;

  always_comb begin
    free_d        = free_q;
    offer_vld_d   = offer_vld_q;
    offer_tag_d   = offer_tag_q;
    rr_ptr_d      = rr_ptr_q;
    outstanding_d = outstanding_q;
    rel_err_d     = cpl_last && !rel_legal;

    for (int j = 0; j < TAG_COUNT; j++) begin
      if (load && (pick == TAG_WIDTH'(j))) begin
        free_d[j] = 1'b0;
      end
      if (rel_legal && (bus.cpl_tag == TAG_WIDTH'(j))) begin
        free_d[j] = 1'b1;
      end
    end

    if (load) begin
      offer_vld_d = 1'b1;
      offer_tag_d = pick;
      rr_ptr_d    = (int'(pick) == TAG_COUNT - 1) ? '0 : pick + 1'b1;
    end else if (fire) begin
      offer_vld_d = 1'b0;
    end

    if (fire && !rel_legal) begin
      outstanding_d = outstanding_q + 1'b1;
    end else if (!fire && rel_legal) begin
      outstanding_d = outstanding_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      free_q        <= '1;
      offer_vld_q   <= 1'b0;
      offer_tag_q   <= '0;
      rr_ptr_q      <= '0;
      outstanding_q <= '0;
      rel_err_q     <= 1'b0;
    end else begin
      free_q        <= free_d;
      offer_vld_q   <= offer_vld_d;
      offer_tag_q   <= offer_tag_d;
      rr_ptr_q      <= rr_ptr_d;
      outstanding_q <= outstanding_d;
      rel_err_q     <= rel_err_d;
    end
  end

  assign bus.alloc_vld   = offer_vld_q;
  assign bus.alloc_tag   = offer_tag_q;
  assign bus.outstanding = outstanding_q;
  assign bus.all_idle    = (outstanding_q == '0);
  assign bus.rel_err     = rel_err_q;

endmodule
`default_nettype wire
